// File: rtl/digital_calendar.sv
// Date keeper driven by the time-of-day clock: advances day/month/year/weekday
// on the 23 -> 0 hour rollover and exposes BCD digits for the display path.
module digital_calendar #(
   parameter logic [6:0] INIT_YEAR    = 7'd0,
   parameter logic [3:0] INIT_MONTH   = 4'd1,
   parameter logic [4:0] INIT_DAY     = 5'd1,
   parameter logic [2:0] INIT_WEEKDAY = 3'd6
) (
   input  logic        clk_1hz,
   input  logic        time_reset,
   input  logic [4:0]  hour_in,
   input  logic        date_ow,
   input  logic [15:0] date_in,
   input  logic [2:0]  weekday_in,
   input  logic        cal_hold,
   input  logic        day_inc,
   input  logic        day_dec,
   output logic [4:0]  day_out,
   output logic [3:0]  month_out,
   output logic [6:0]  year_out,
   output logic [2:0]  weekday_out,
   output logic        new_day,
   output logic [3:0]  day_1s,
   output logic [3:0]  day_10s,
   output logic [3:0]  mon_1s,
   output logic [3:0]  mon_10s,
   output logic [3:0]  yr_1s,
   output logic [3:0]  yr_10s
);

   logic [4:0] day_q, day_d;
   logic [3:0] month_q, month_d;
   logic [6:0] year_q, year_d;
   logic [2:0] weekday_q, weekday_d;
   logic       new_day_q, new_day_d;
   logic [4:0] prev_hour_q, prev_hour_d;

   logic       tick;
   logic [4:0] cur_dim;
   logic [6:0] ow_year;
   logic [3:0] ow_month;
   logic [4:0] ow_day;
   logic [2:0] ow_weekday;

   // Only the low two year bits matter: every multiple of 4 in 2000-2099 is a leap year.
   function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [1:0] yl);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
         4'd2:                    days_in_month = (yl == 2'd0) ? 5'd29 : 5'd28;
         default:                 days_in_month = 5'd31;
      endcase
   endfunction

   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      to_bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   always_comb begin
      tick    = (prev_hour_q == 5'd23) && (hour_in == 5'd0);
      cur_dim = days_in_month(month_q, year_q[1:0]);

      ow_year    = (date_in[15:9] > 7'd99) ? 7'd0 : date_in[15:9];
      ow_month   = (date_in[8:5] == 4'd0 || date_in[8:5] > 4'd12) ? 4'd1 : date_in[8:5];
      ow_day     = (date_in[4:0] == 5'd0 ||
                    date_in[4:0] > days_in_month(ow_month, ow_year[1:0])) ? 5'd1 : date_in[4:0];
      ow_weekday = (weekday_in == 3'd7) ? 3'd0 : weekday_in;
   end

   always_comb begin
      day_d       = day_q;
      month_d     = month_q;
      year_d      = year_q;
      weekday_d   = weekday_q;
      new_day_d   = 1'b0;
      prev_hour_d = hour_in;

      if (date_ow) begin
         day_d     = ow_day;
         month_d   = ow_month;
         year_d    = ow_year;
         weekday_d = ow_weekday;
      end else if (cal_hold) begin
         // Manual adjust stays inside the current month; a rollover seen here is dropped.
         if (day_inc && !day_dec) begin
            day_d = (day_q >= cur_dim) ? 5'd1 : day_q + 5'd1;
         end else if (day_dec && !day_inc) begin
            day_d = (day_q <= 5'd1) ? cur_dim : day_q - 5'd1;
         end
      end else if (tick) begin
         new_day_d = 1'b1;
         weekday_d = (weekday_q == 3'd6) ? 3'd0 : weekday_q + 3'd1;
         if (day_q < cur_dim) begin
            day_d = day_q + 5'd1;
         end else begin
            day_d = 5'd1;
            if (month_q >= 4'd12) begin
               month_d = 4'd1;
               year_d  = (year_q >= 7'd99) ? 7'd0 : year_q + 7'd1;
            end else begin
               month_d = month_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_1hz or posedge time_reset) begin
      if (time_reset) begin
         day_q       <= INIT_DAY;
         month_q     <= INIT_MONTH;
         year_q      <= INIT_YEAR;
         weekday_q   <= INIT_WEEKDAY;
         new_day_q   <= 1'b0;
         prev_hour_q <= 5'd0;
      end else begin
         day_q       <= day_d;
         month_q     <= month_d;
         year_q      <= year_d;
         weekday_q   <= weekday_d;
         new_day_q   <= new_day_d;
         prev_hour_q <= prev_hour_d;
      end
   end

   assign day_out     = day_q;
   assign month_out   = month_q;
   assign year_out    = year_q;
   assign weekday_out = weekday_q;
   assign new_day     = new_day_q;

   assign {day_10s, day_1s} = to_bcd({2'b00, day_q});
   assign {mon_10s, mon_1s} = to_bcd({3'b000, month_q});
   assign {yr_10s, yr_1s}   = to_bcd(year_q);

endmodule

// File: tb/tb_digital_calendar.sv
// Directed self-checking bench for digital_calendar: rollover, leap years,
// year wrap, overwrite validation, manual hold adjust and async reset.
module tb_digital_calendar;

   logic        clk_1hz;
   logic        time_reset;
   logic [4:0]  hour_in;
   logic        date_ow;
   logic [15:0] date_in;
   logic [2:0]  weekday_in;
   logic        cal_hold;
   logic        day_inc;
   logic        day_dec;
   logic [4:0]  day_out;
   logic [3:0]  month_out;
   logic [6:0]  year_out;
   logic [2:0]  weekday_out;
   logic        new_day;
   logic [3:0]  day_1s, day_10s, mon_1s, mon_10s, yr_1s, yr_10s;

   int checks = 0;
   int passes = 0;

   digital_calendar dut (
      .clk_1hz(clk_1hz), .time_reset(time_reset), .hour_in(hour_in),
      .date_ow(date_ow), .date_in(date_in), .weekday_in(weekday_in),
      .cal_hold(cal_hold), .day_inc(day_inc), .day_dec(day_dec),
      .day_out(day_out), .month_out(month_out), .year_out(year_out),
      .weekday_out(weekday_out), .new_day(new_day),
      .day_1s(day_1s), .day_10s(day_10s), .mon_1s(mon_1s), .mon_10s(mon_10s),
      .yr_1s(yr_1s), .yr_10s(yr_10s)
   );

   initial clk_1hz = 1'b0;
   always #5 clk_1hz = ~clk_1hz;

   task automatic step();
      @(posedge clk_1hz);
      #1;
   endtask

   task automatic load(input logic [6:0] y, input logic [3:0] m, input logic [4:0] d,
                       input logic [2:0] wd);
      date_ow    = 1'b1;
      date_in    = {y, m, d};
      weekday_in = wd;
      step();
      date_ow    = 1'b0;
   endtask

   task automatic rollover();
      hour_in = 5'd23;
      step();
      hour_in = 5'd0;
      step();
   endtask

   task automatic test_reset();
      time_reset = 1'b1;
      hour_in = 5'd0; date_ow = 1'b0; date_in = 16'd0; weekday_in = 3'd0;
      cal_hold = 1'b0; day_inc = 1'b0; day_dec = 1'b0;
      #2;
      checks++; if (day_out !== 5'd1) $display("[TB] FAIL rst_day got %0d exp 1", day_out); else passes++;
      checks++; if (month_out !== 4'd1) $display("[TB] FAIL rst_month got %0d exp 1", month_out); else passes++;
      checks++; if (year_out !== 7'd0) $display("[TB] FAIL rst_year got %0d exp 0", year_out); else passes++;
      checks++; if (weekday_out !== 3'd6) $display("[TB] FAIL rst_weekday got %0d exp 6", weekday_out); else passes++;
      checks++; if (new_day !== 1'b0) $display("[TB] FAIL rst_new_day got %0d exp 0", new_day); else passes++;
      @(negedge clk_1hz);
      time_reset = 1'b0;
   endtask

   task automatic test_first_rollover();
      rollover();
      checks++; if (day_out !== 5'd2) $display("[TB] FAIL t1_day got %0d exp 2", day_out); else passes++;
      checks++; if (weekday_out !== 3'd0) $display("[TB] FAIL t1_weekday got %0d exp 0", weekday_out); else passes++;
      checks++; if (new_day !== 1'b1) $display("[TB] FAIL t1_new_day got %0d exp 1", new_day); else passes++;
      checks++; if ({day_10s, day_1s} !== 8'h02) $display("[TB] FAIL t1_day_bcd got %h exp 02", {day_10s, day_1s}); else passes++;
      step();
      checks++; if (new_day !== 1'b0) $display("[TB] FAIL t1_new_day_pulse got %0d exp 0", new_day); else passes++;
      checks++; if (day_out !== 5'd2) $display("[TB] FAIL t1_day_hold got %0d exp 2", day_out); else passes++;
   endtask

   task automatic test_leap_year();
      load(7'd24, 4'd2, 5'd28, 3'd3);
      checks++; if (day_out !== 5'd28 || month_out !== 4'd2 || year_out !== 7'd24)
         $display("[TB] FAIL t2_load got %0d-%0d-%0d exp 24-2-28", year_out, month_out, day_out); else passes++;
      checks++; if (new_day !== 1'b0) $display("[TB] FAIL t2_load_new_day got %0d exp 0", new_day); else passes++;
      rollover();
      checks++; if (day_out !== 5'd29 || month_out !== 4'd2) $display("[TB] FAIL t2_feb29 got %0d-%0d exp 2-29", month_out, day_out); else passes++;
      checks++; if (weekday_out !== 3'd4) $display("[TB] FAIL t2_weekday1 got %0d exp 4", weekday_out); else passes++;
      rollover();
      checks++; if (day_out !== 5'd1 || month_out !== 4'd3) $display("[TB] FAIL t2_mar1 got %0d-%0d exp 3-1", month_out, day_out); else passes++;
      checks++; if ({mon_10s, mon_1s} !== 8'h03) $display("[TB] FAIL t2_mon_bcd got %h exp 03", {mon_10s, mon_1s}); else passes++;
      checks++; if (weekday_out !== 3'd5) $display("[TB] FAIL t2_weekday2 got %0d exp 5", weekday_out); else passes++;
      load(7'd23, 4'd2, 5'd28, 3'd0);
      rollover();
      checks++; if (day_out !== 5'd1 || month_out !== 4'd3 || year_out !== 7'd23)
         $display("[TB] FAIL t2_nonleap got %0d-%0d-%0d exp 23-3-1", year_out, month_out, day_out); else passes++;
   endtask

   task automatic test_year_wrap();
      load(7'd99, 4'd12, 5'd31, 3'd4);
      checks++; if ({yr_10s, yr_1s} !== 8'h99) $display("[TB] FAIL t3_yr_bcd99 got %h exp 99", {yr_10s, yr_1s}); else passes++;
      checks++; if ({day_10s, day_1s} !== 8'h31) $display("[TB] FAIL t3_day_bcd31 got %h exp 31", {day_10s, day_1s}); else passes++;
      checks++; if ({mon_10s, mon_1s} !== 8'h12) $display("[TB] FAIL t3_mon_bcd12 got %h exp 12", {mon_10s, mon_1s}); else passes++;
      rollover();
      checks++; if (day_out !== 5'd1 || month_out !== 4'd1 || year_out !== 7'd0)
         $display("[TB] FAIL t3_wrap got %0d-%0d-%0d exp 0-1-1", year_out, month_out, day_out); else passes++;
      checks++; if (weekday_out !== 3'd5) $display("[TB] FAIL t3_weekday got %0d exp 5", weekday_out); else passes++;
      checks++; if ({yr_10s, yr_1s} !== 8'h00) $display("[TB] FAIL t3_yr_bcd00 got %h exp 00", {yr_10s, yr_1s}); else passes++;
   endtask

   task automatic test_overwrite_validation();
      load(7'd120, 4'd13, 5'd31, 3'd7);
      checks++; if (year_out !== 7'd0) $display("[TB] FAIL t4_year got %0d exp 0", year_out); else passes++;
      checks++; if (month_out !== 4'd1) $display("[TB] FAIL t4_month got %0d exp 1", month_out); else passes++;
      checks++; if (day_out !== 5'd31) $display("[TB] FAIL t4_day got %0d exp 31", day_out); else passes++;
      checks++; if (weekday_out !== 3'd0) $display("[TB] FAIL t4_weekday got %0d exp 0", weekday_out); else passes++;
      load(7'd0, 4'd4, 5'd31, 3'd2);
      checks++; if (day_out !== 5'd1 || month_out !== 4'd4) $display("[TB] FAIL t4_apr31 got %0d-%0d exp 4-1", month_out, day_out); else passes++;
      load(7'd1, 4'd2, 5'd29, 3'd2);
      checks++; if (day_out !== 5'd1) $display("[TB] FAIL t4_feb29_nonleap got %0d exp 1", day_out); else passes++;
      load(7'd0, 4'd0, 5'd0, 3'd2);
      checks++; if (day_out !== 5'd1 || month_out !== 4'd1) $display("[TB] FAIL t4_zeros got %0d-%0d exp 1-1", month_out, day_out); else passes++;
   endtask

   task automatic test_hold_adjust();
      load(7'd0, 4'd4, 5'd30, 3'd1);
      cal_hold = 1'b1;
      day_inc = 1'b1;
      step();
      checks++; if (day_out !== 5'd1 || month_out !== 4'd4) $display("[TB] FAIL t5_inc_wrap got %0d-%0d exp 4-1", month_out, day_out); else passes++;
      checks++; if (weekday_out !== 3'd1) $display("[TB] FAIL t5_inc_weekday got %0d exp 1", weekday_out); else passes++;
      day_inc = 1'b0; day_dec = 1'b1;
      step();
      checks++; if (day_out !== 5'd30) $display("[TB] FAIL t5_dec_wrap got %0d exp 30", day_out); else passes++;
      day_dec = 1'b1; day_inc = 1'b1;
      step();
      checks++; if (day_out !== 5'd30) $display("[TB] FAIL t5_both got %0d exp 30", day_out); else passes++;
      day_inc = 1'b0; day_dec = 1'b1;
      step();
      checks++; if (day_out !== 5'd29) $display("[TB] FAIL t5_dec got %0d exp 29", day_out); else passes++;
      day_dec = 1'b0;
      rollover();
      checks++; if (day_out !== 5'd29 || new_day !== 1'b0)
         $display("[TB] FAIL t5_hold_tick got day %0d new_day %0d exp 29 0", day_out, new_day); else passes++;
      cal_hold = 1'b0;
      step();
      checks++; if (day_out !== 5'd29 || new_day !== 1'b0) $display("[TB] FAIL t5_not_queued got %0d exp 29", day_out); else passes++;
      day_inc = 1'b1;
      step();
      day_inc = 1'b0;
      checks++; if (day_out !== 5'd29) $display("[TB] FAIL t5_inc_no_hold got %0d exp 29", day_out); else passes++;
      hour_in = 5'd22; step();
      hour_in = 5'd0;  step();
      checks++; if (day_out !== 5'd29 || new_day !== 1'b0) $display("[TB] FAIL t5_22_to_0 got %0d exp 29", day_out); else passes++;
      hour_in = 5'd23; step();
      hour_in = 5'd5;  step();
      checks++; if (day_out !== 5'd29 || new_day !== 1'b0) $display("[TB] FAIL t5_23_to_5 got %0d exp 29", day_out); else passes++;
      rollover();
      checks++; if (day_out !== 5'd30 || new_day !== 1'b1) $display("[TB] FAIL t5_resume got %0d exp 30", day_out); else passes++;
   endtask

   task automatic test_async_reset();
      hour_in = 5'd23;
      step();
      hour_in = 5'd0;
      #3;
      time_reset = 1'b1;
      #1;
      checks++; if (day_out !== 5'd1 || month_out !== 4'd1 || year_out !== 7'd0)
         $display("[TB] FAIL t6_async got %0d-%0d-%0d exp 0-1-1", year_out, month_out, day_out); else passes++;
      @(posedge clk_1hz);
      #1;
      checks++; if (day_out !== 5'd1 || weekday_out !== 3'd6) $display("[TB] FAIL t6_edge got day %0d wd %0d exp 1 6", day_out, weekday_out); else passes++;
      checks++; if (new_day !== 1'b0) $display("[TB] FAIL t6_new_day got %0d exp 0", new_day); else passes++;
      @(negedge clk_1hz);
      time_reset = 1'b0;
      hour_in = 5'd0;
      step();
      hour_in = 5'd1;
      step();
      checks++; if (day_out !== 5'd1 || new_day !== 1'b0) $display("[TB] FAIL t6_after got day %0d new_day %0d exp 1 0", day_out, new_day); else passes++;
   endtask

   initial begin
      test_reset();
      test_first_rollover();
      test_leap_year();
      test_year_wrap();
      test_overwrite_validation();
      test_hold_adjust();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/digital_calendar.md
Name: digital_calendar

Overview:
- Consumes the 5-bit hour output of the time-of-day clock and keeps day, month, year and weekday.
- Detects the hour rollover 23 -> 0 and advances the date by one day.
- Handles month lengths and leap years for the range 2000-2099.
- Drives BCD date digits for the display path, alongside the clock's BCD time digits.

Parameters:
INIT_YEAR, 7'd0, year offset from 2000 loaded on reset (0..99)
INIT_MONTH, 4'd1, month loaded on reset (1..12)
INIT_DAY, 5'd1, day loaded on reset (1..31)
INIT_WEEKDAY, 3'd6, weekday loaded on reset (0=Sunday..6=Saturday; 2000-01-01 is Saturday)

Ports:
clk_1hz  input  1  1 Hz system tick, same clock as the time-of-day clock
time_reset  input  1  asynchronous, active-high reset to INIT_* values
hour_in  input  5  current hour (0..23) from the time-of-day clock
date_ow  input  1  synchronous date overwrite strobe
date_in  input  16  overwrite value {year[6:0], month[3:0], day[4:0]}
weekday_in  input  3  overwrite weekday, loaded with date_ow
cal_hold  input  1  1 = freeze automatic advance and enable manual day adjust
day_inc  input  1  manual day increment; honoured only while cal_hold=1
day_dec  input  1  manual day decrement; honoured only while cal_hold=1
day_out  output  5  binary day 1..31
month_out  output  4  binary month 1..12
year_out  output  7  binary year offset 0..99
weekday_out  output  3  weekday 0..6
new_day  output  1  one-cycle pulse when an automatic day advance is applied
day_1s, day_10s, mon_1s, mon_10s, yr_1s, yr_10s  output  4 each  BCD digits of day_out, month_out, year_out

Behaviour:
- Reset (time_reset=1, async):
  - day/month/year/weekday = INIT_*; new_day=0.
  - Internal prev_hour=0.
  - Reset asserted mid-advance discards the advance.
- Every clk_1hz edge, prev_hour <= hour_in, unconditionally.
- Rollover tick = (prev_hour==23 && hour_in==0). Only this transition ticks; any other hour jump, including 23 -> 5 or 22 -> 0, does not.
- Priority per edge: date_ow > cal_hold manual adjust > rollover tick.
- date_ow=1:
  - Load date_in and weekday_in; new_day=0; any tick that edge is dropped.
  - Validation: year>99 -> 0; month 0 or >12 -> 1; day 0 or > days_in_month(loaded month, loaded year) -> 1; weekday 7 -> 0.
- cal_hold=1:
  - Rollover ticks are ignored and lost, not queued; new_day=0.
  - day_inc=1: day wraps days_in_month -> 1 within the same month. Month, year and weekday are unchanged.
  - day_dec=1: day wraps 1 -> days_in_month.
  - day_inc and day_dec both high: no change.
- Tick with cal_hold=0:
  - new_day=1 for exactly one cycle.
  - weekday = (weekday==6) ? 0 : weekday+1.
  - If day < days_in_month: day+1.
  - Else day=1, and month advances (12 -> 1 with year+1; year 99 -> 0).
- days_in_month:
  - Months 4, 6, 9, 11 = 30.
  - Month 2 = 29 if year[1:0]==0, else 28.
  - All others = 31.
- BCD outputs are combinational from the binary registers (x/10, x%10); yr digits span 00..99.
- Latency: the date updates on the same edge where hour_in first reads 0 after 23.
- All outputs registered except the BCD digits.

Test Plan:
1. Reset with defaults; drive hour_in 23 then 0 -> date goes 2000-01-01 Sat(6) -> 2000-01-02 Sun(0); new_day high for one cycle; day_10s=0, day_1s=2.
2. date_ow with year 24, month 2, day 28, then hour 23 -> 0 twice -> 2024-02-29, then 2024-03-01. Repeat with year 23 -> 2023-03-01 after a single rollover.
3. date_ow with year 99, month 12, day 31, weekday 4; rollover -> year 0, month 1, day 1, weekday 5; yr_1s=0, yr_10s=0.
4. date_ow with year 120, month 13, day 31, weekday 7 -> loaded year 0, month 1, day 31, weekday 0. Then date_ow with month 4, day 31 -> day 1.
5. cal_hold=1 at month 4, day 30: day_inc -> day 1, month still 4; day_dec -> day 30. A 23 -> 0 rollover during hold -> no change, new_day=0. Hour 22 -> 0 with cal_hold=0 -> no tick.
6. Assert time_reset asynchronously on the same cycle as a 23 -> 0 rollover -> outputs equal INIT_*; new_day=0; after release, hour 0 -> 1 produces no tick.
